mem_1024x8: RTL and testbench



---
 rtl/mem1024x8_pkg.sv | 17 +
 rtl/mem_1024x8_if.sv | 34 +++
 rtl/mem_valid_tracker.sv | 27 ++
 rtl/mem_1024x8.sv | 71 +++++++
 tb/tb_mem_1024x8.sv | 285 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem1024x8_pkg.sv
// mem_1024x8 shared constants and types.
// Optional read-parity build: MEM1024X8_PARITY_EN.
package mem1024x8_pkg;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 10;
  localparam int DEPTH  = 2**ADDR_W;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [DATA_W-1:0] data_t;

  // Even parity bit: makes total ones count even.
  function automatic logic even_par(data_t d);
    return ^d;
  endfunction

endpackage

// File: rtl/mem_1024x8_if.sv
// Bus bundle for mem_1024x8.
// parity_err exists only with MEM1024X8_PARITY_EN.
interface mem_1024x8_if;
  import mem1024x8_pkg::*;

  logic  wr;
  addr_t address;
  data_t data_in;
  data_t data_out;
`ifdef MEM1024X8_PARITY_EN
  logic  parity_err;
`endif

`ifdef MEM1024X8_PARITY_EN
  modport master (
    output wr, address, data_in,
    input  data_out, parity_err
  );
  modport slave (
    input  wr, address, data_in,
    output data_out, parity_err
  );
`else
  modport master (
    output wr, address, data_in,
    input  data_out
  );
  modport slave (
    input  wr, address, data_in,
    output data_out
  );
`endif

endinterface

// File: rtl/mem_valid_tracker.sv
// Per-word valid bits for mem_1024x8.
// Async clear, set on write, combinational lookup.
module mem_valid_tracker
  import mem1024x8_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  logic  i_set,
  input  addr_t i_set_addr,
  input  addr_t i_rd_addr,
  output logic  o_valid
);

  logic [DEPTH-1:0] r_valid;

  // Clear all words on reset, mark written words valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
    end else if (i_set) begin
      r_valid[i_set_addr] <= 1'b1;
    end
  end

  assign o_valid = r_valid[i_rd_addr];

endmodule

// File: rtl/mem_1024x8.sv
// 1024x8 single-port RAM, registered read, cleared via valid bits.
// Optional read-parity build: MEM1024X8_PARITY_EN.
module mem_1024x8
  import mem1024x8_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  mem_1024x8_if.slave  bus
);

  data_t r_mem [DEPTH];
  data_t r_dout;
  data_t w_word;
  logic  w_valid;

  // Array is never reset; stale contents are masked by valid bits.
  always_ff @(posedge clk) begin
    if (bus.wr) begin
      r_mem[bus.address] <= bus.data_in;
    end
  end

  mem_valid_tracker u_valid (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_set      (bus.wr),
    .i_set_addr (bus.address),
    .i_rd_addr  (bus.address),
    .o_valid    (w_valid)
  );

  assign w_word = r_mem[bus.address];

  // Read register: loads only on read cycles, holds during writes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dout <= '0;
    end else if (!bus.wr) begin
      r_dout <= w_valid ? w_word : '0;
    end
  end

  assign bus.data_out = r_dout;

`ifdef MEM1024X8_PARITY_EN
  logic r_par [DEPTH];
  logic r_perr;
  logic w_par;

  // Parity bit stored alongside each written word.
  always_ff @(posedge clk) begin
    if (bus.wr) begin
      r_par[bus.address] <= even_par(bus.data_in);
    end
  end

  assign w_par = r_par[bus.address];

  // Parity check registered with the read data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_perr <= 1'b0;
    end else if (!bus.wr) begin
      r_perr <= w_valid && (w_par != even_par(w_word));
    end
  end

  assign bus.parity_err = r_perr;
`endif

endmodule

// File: tb/tb_mem_1024x8.sv
// Self-checking bench for mem_1024x8.
// Parity scenario compiled only with MEM1024X8_PARITY_EN.
module tb_mem_1024x8;
  import mem1024x8_pkg::*;

  logic clk;
  logic rst_n;

  mem_1024x8_if bus ();

  mem_1024x8 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  data_t m_mem   [DEPTH];
  bit    m_valid [DEPTH];
  data_t m_dout;

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) m_valid[i] = 1'b0;
    m_dout = '0;
  endtask

  task automatic drive_write(input addr_t a, input data_t d);
    @(negedge clk);
    bus.wr      = 1'b1;
    bus.address = a;
    bus.data_in = d;
    @(posedge clk);
    #1;
    m_mem[a]   = d;
    m_valid[a] = 1'b1;
  endtask

  task automatic drive_read(input addr_t a);
    @(negedge clk);
    bus.wr      = 1'b0;
    bus.address = a;
    bus.data_in = data_t'($urandom);
    @(posedge clk);
    #1;
    m_dout = m_valid[a] ? m_mem[a] : '0;
  endtask

  task automatic test_reset();
    rst_n       = 1'b0;
    bus.wr      = 1'b1;
    bus.address = addr_t'(5);
    bus.data_in = 8'h77;
    model_reset();
    #20;
    n_checks++;
    if (bus.data_out !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_dout got=%h exp=00", bus.data_out);
    end
`ifdef MEM1024X8_PARITY_EN
    n_checks++;
    if (bus.parity_err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_perr got=%b exp=0", bus.parity_err);
    end
`endif
    @(negedge clk);
    bus.wr = 1'b0;
    rst_n  = 1'b1;
    begin
      addr_t addrs [3];
      addrs[0] = 10'd0;
      addrs[1] = 10'd5;
      addrs[2] = 10'd1023;
      for (int i = 0; i < 3; i++) begin
        drive_read(addrs[i]);
        n_checks++;
        if (bus.data_out !== 8'h00) begin
          n_fail++;
          $display("FAIL post_reset_read a=%0d got=%h exp=00",
                   addrs[i], bus.data_out);
        end
      end
    end
  endtask

  task automatic test_write_read();
    addr_t a [3];
    data_t d [3];
    a[0] = 10'd10;   d[0] = 8'hA5;
    a[1] = 10'd512;  d[1] = 8'h3C;
    a[2] = 10'd1023; d[2] = 8'hFF;
    for (int i = 0; i < 3; i++) drive_write(a[i], d[i]);
    for (int i = 0; i < 3; i++) begin
      drive_read(a[i]);
      n_checks++;
      if (bus.data_out !== d[i]) begin
        n_fail++;
        $display("FAIL wr_rd a=%0d got=%h exp=%h",
                 a[i], bus.data_out, d[i]);
      end
    end
  endtask

  task automatic test_overwrite();
    data_t prior;
    drive_read(10'd10);
    prior = m_dout;
    drive_write(10'd7, 8'h11);
    n_checks++;
    if (bus.data_out !== prior) begin
      n_fail++;
      $display("FAIL ow_hold1 got=%h exp=%h", bus.data_out, prior);
    end
    drive_write(10'd7, 8'h22);
    n_checks++;
    if (bus.data_out !== prior) begin
      n_fail++;
      $display("FAIL ow_hold2 got=%h exp=%h", bus.data_out, prior);
    end
    drive_read(10'd7);
    n_checks++;
    if (bus.data_out !== 8'h22) begin
      n_fail++;
      $display("FAIL overwrite got=%h exp=22", bus.data_out);
    end
  endtask

  task automatic test_back_to_back();
    drive_write(10'd300, 8'h9E);
    drive_read(10'd300);
    n_checks++;
    if (bus.data_out !== 8'h9E) begin
      n_fail++;
      $display("FAIL b2b got=%h exp=9e", bus.data_out);
    end
  endtask

  task automatic test_mid_reset();
    drive_write(10'd100, 8'h55);
    drive_read(10'd100);
    n_checks++;
    if (bus.data_out !== 8'h55) begin
      n_fail++;
      $display("FAIL mid_pre got=%h exp=55", bus.data_out);
    end
    #1;
    rst_n = 1'b0;
    #1;
    model_reset();
    n_checks++;
    if (bus.data_out !== 8'h00) begin
      n_fail++;
      $display("FAIL mid_async_clr got=%h exp=00", bus.data_out);
    end
    #1;
    rst_n = 1'b1;
    drive_read(10'd100);
    n_checks++;
    if (bus.data_out !== 8'h00) begin
      n_fail++;
      $display("FAIL mid_invalid got=%h exp=00", bus.data_out);
    end
    drive_read(10'd10);
    n_checks++;
    if (bus.data_out !== 8'h00) begin
      n_fail++;
      $display("FAIL mid_invalid10 got=%h exp=00", bus.data_out);
    end
    drive_write(10'd100, 8'h66);
    drive_read(10'd100);
    n_checks++;
    if (bus.data_out !== 8'h66) begin
      n_fail++;
      $display("FAIL mid_rewrite got=%h exp=66", bus.data_out);
    end
  endtask

  task automatic test_boundary();
    drive_write(10'd0, 8'h01);
    drive_write(10'd1023, 8'h80);
    drive_read(10'd0);
    n_checks++;
    if (bus.data_out !== 8'h01) begin
      n_fail++;
      $display("FAIL bnd_0 got=%h exp=01", bus.data_out);
    end
    drive_read(10'd1023);
    n_checks++;
    if (bus.data_out !== 8'h80) begin
      n_fail++;
      $display("FAIL bnd_1023 got=%h exp=80", bus.data_out);
    end
    drive_read(10'd1);
    n_checks++;
    if (bus.data_out !== 8'h00) begin
      n_fail++;
      $display("FAIL bnd_1 got=%h exp=00", bus.data_out);
    end
  endtask

  task automatic test_random();
    addr_t a;
    data_t d;
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 3))
        0: a = addr_t'($urandom_range(0, 15));
        1: a = addr_t'($urandom_range(1008, 1023));
        2: a = addr_t'($urandom);
        default: a = addr_t'($urandom_range(500, 520));
      endcase
      d = data_t'($urandom);
      if ($urandom_range(0, 1) == 1) begin
        drive_write(a, d);
        n_checks++;
        if (bus.data_out !== m_dout) begin
          n_fail++;
          $display("FAIL rnd_hold i=%0d a=%0d got=%h exp=%h",
                   i, a, bus.data_out, m_dout);
        end
      end else begin
        drive_read(a);
        n_checks++;
        if (bus.data_out !== m_dout) begin
          n_fail++;
          $display("FAIL rnd_read i=%0d a=%0d got=%h exp=%h",
                   i, a, bus.data_out, m_dout);
        end
      end
    end
  endtask

`ifdef MEM1024X8_PARITY_EN
  task automatic test_parity();
    drive_write(10'd20, 8'h0F);
    drive_read(10'd20);
    n_checks++;
    if (bus.parity_err !== 1'b0) begin
      n_fail++;
      $display("FAIL par_clean got=%b exp=0", bus.parity_err);
    end
    @(negedge clk);
    dut.r_par[20] = ~dut.r_par[20];
    drive_read(10'd20);
    n_checks++;
    if (bus.data_out !== 8'h0F) begin
      n_fail++;
      $display("FAIL par_data got=%h exp=0f", bus.data_out);
    end
    n_checks++;
    if (bus.parity_err !== 1'b1) begin
      n_fail++;
      $display("FAIL par_err got=%b exp=1", bus.parity_err);
    end
    drive_read(10'd21);
    n_checks++;
    if (bus.parity_err !== 1'b0) begin
      n_fail++;
      $display("FAIL par_invalid got=%b exp=0", bus.parity_err);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_write_read();
    test_overwrite();
    test_back_to_back();
    test_mid_reset();
    test_boundary();
    test_random();
`ifdef MEM1024X8_PARITY_EN
    test_parity();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
